// File: rtl/mac_accum_seq.sv
// Dot-product sequencer around a combinational mac_unit: feeds the running sum back as mac_c.
// Optional MAC_ACC_BIAS_EN adds in_bias, used as the first-beat mac_c instead of ACC_INIT.
module mac_accum_seq #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          CNT_W    = 8,
  parameter logic [DATA_W-1:0]    ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
`ifdef MAC_ACC_BIAS_EN
  input  logic [DATA_W-1:0] in_bias,
`endif
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [DATA_W-1:0] mac_c,
  output logic              mac_mode,
  input  logic [DATA_W-1:0] mac_out,
  input  logic              mac_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_error,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_error_q, out_error_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               fire;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  seed;

`ifdef MAC_ACC_BIAS_EN
  assign seed = in_bias;
`else
  assign seed = ACC_INIT;
`endif

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_error = out_error_q;
  assign out_count = out_count_q;

  assign mac_a    = in_a;
  assign mac_b    = in_b;
  assign mac_c    = (state_q == IDLE) ? seed : acc_q;
  assign mac_mode = (state_q == IDLE) ? mode : mode_q;

  assign fire    = in_valid & in_ready;
  // beat counter saturates rather than wrapping
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_error_d = out_error_q;
    out_count_d = out_count_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          mode_d = mode;
          err_d  = mac_err;
          cnt_d  = CNT_W'(1);
          if (in_last) begin
            out_data_d  = mac_out;
            out_error_d = mac_err;
            out_count_d = CNT_W'(1);
            state_d     = OUT;
          end else begin
            acc_d   = mac_out;
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (fire) begin
          err_d = err_q | mac_err;
          cnt_d = cnt_inc;
          if (in_last) begin
            out_data_d  = mac_out;
            out_error_d = err_q | mac_err;
            out_count_d = cnt_inc;
            state_d     = OUT;
          end else begin
            acc_d = mac_out;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = ACC_INIT;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= ACC_INIT;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_error_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_error_q <= out_error_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_mac_accum_seq.sv
// Scoreboard bench for mac_accum_seq with a behavioural stand-in for mac_unit.
// Expected results come from a per-packet dot-product model in plain arithmetic.
module tb_mac_accum_seq;

  localparam int SAT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic [15:0] in_bias = '0;
  logic [15:0] mac_a, mac_b, mac_c, mac_out;
  logic        mac_mode;
  logic        mac_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_error;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] pa[$];
  logic [15:0] pb[$];
  logic        perr[$];
  logic [15:0] pbias;

  int stall = 0;
  bit rdy_rand = 1'b0;

  always #5 clk = ~clk;

  mac_accum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
`ifdef MAC_ACC_BIAS_EN
    .in_bias   (in_bias),
`endif
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_mode  (mac_mode),
    .mac_out   (mac_out),
    .mac_err   (mac_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error),
    .out_count (out_count)
  );

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(h[9:0]);
    real v;
    if (e == 0) v = m / 1024.0 * pow2(-14);
    else v = (1.0 + m / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  // truncating real -> half, enough for a stand-in mac_unit
  function automatic logic [15:0] r2h(input real r);
    logic s = (r < 0.0);
    real  x = s ? -r : r;
    int   e = 15;
    int   m;
    if (x == 0.0) return {s, 15'd0};
    if (x >= 65520.0) return {s, 15'h7C00};
    while (x >= 2.0 && e < 40) begin x = x / 2.0; e++; end
    while (x < 1.0 && e > 1) begin x = x * 2.0; e--; end
    if (e >= 31) return {s, 15'h7C00};
    if (x < 1.0) begin
      m = $rtoi(x * 1024.0);
      return {s, 5'd0, m[9:0]};
    end
    m = $rtoi((x - 1.0) * 1024.0);
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic m);
    logic signed [15:0] p;
    if (!m) begin
      p = $signed(a[7:0]) * $signed(b[7:0]);
      return p + c;
    end
    return r2h(h2r(a) * h2r(b) + h2r(c));
  endfunction

  always_comb mac_out = mac_fn(mac_a, mac_b, mac_c, mac_mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input bit m, input bit bubbles, input bit no_last,
                          input bit use_exp, input logic [15:0] ed,
                          input bit ee, input int ec);
    int          n = pa.size();
    logic [15:0] acc;
    logic        err = 1'b0;
    int          cnt = 0;
    int          w;
`ifdef MAC_ACC_BIAS_EN
    acc = pbias;
`else
    acc = 16'h0000;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      mac_err  = perr[i];
      mode     = (i == 0) ? m : 1'($urandom_range(0, 1));
      in_bias  = (i == 0) ? pbias : 16'($urandom);
      in_last  = !no_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      acc = mac_fn(pa[i], pb[i], acc, m);
      err = err | perr[i];
      if (cnt < SAT) cnt++;
      if (in_last) begin
        if (use_exp) exp_q.push_back('{ed, ee, ec});
        else exp_q.push_back('{acc, err, cnt});
      end
      if (bubbles && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    mac_err  = 1'b0;
  endtask

  task automatic fill(input int n, input logic [15:0] a, input logic [15:0] b);
    pa.delete();
    pb.delete();
    perr.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(a);
      pb.push_back(b);
      perr.push_back(1'b0);
    end
    pbias = 16'h0000;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_error"}, 32'(out_error), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
`ifndef MAC_ACC_BIAS_EN
    chk({tag, "_mac_c"}, 32'(mac_c), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    bit r;
    if (!rst) begin
      r = (stall > 0) ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (stall > 0 && out_valid) stall--;
      chk("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].data));
          chk("out_error", 32'(out_error), 32'(exp_q[0].err));
          chk("out_count", 32'(out_count), 32'(exp_q[0].cnt));
          if (r) void'(exp_q.pop_front());
        end
      end
      out_ready = r;
    end
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // INT8 4x(3*4)
    fill(4, 16'd3, 16'd4);
    send_pkt(1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0, 4);

    // FP16 3x(1.0*2.0)
    fill(3, 16'h3C00, 16'h4000);
    send_pkt(1'b1, 1'b0, 1'b0, 1'b1, 16'h4600, 1'b0, 3);

    // backpressure: result held for 5 cycles while next packet waits
    stall = 5;
    fill(2, 16'd2, 16'd3);
    send_pkt(1'b0, 1'b0, 1'b0, 1'b1, 16'h000C, 1'b0, 2);
    fill(1, 16'd7, 16'd1);
    send_pkt(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 1);

    // bubbles across INT8 packet
    fill(4, 16'd1, 16'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    pa.delete(); pb.delete(); perr.delete();
    for (int i = 0; i < 4; i++) begin
      pa.push_back(16'd1); pb.push_back(16'd2); perr.push_back(1'b0);
    end
    send_pkt(1'b0, 1'b1, 1'b0, 1'b1, 16'h0008, 1'b0, 4);

    // error on first beat is sticky
    fill(2, 16'h7BFF, 16'h7BFF);
    perr[0] = 1'b1;
    send_pkt(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0);

    // saturation of beat counter
    fill(300, 16'd0, 16'd0);
    send_pkt(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, SAT);

    // reset mid-packet, then single-beat packet
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    fill(3, 16'd9, 16'd9);
    send_pkt(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    fill(1, 16'd5, 16'd5);
    send_pkt(1'b0, 1'b0, 1'b0, 1'b1, 16'h0019, 1'b0, 1);

    // randomized packets
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      bit m = 1'($urandom_range(0, 1));
      int n = $urandom_range(1, 8);
      pa.delete(); pb.delete(); perr.delete();
      for (int i = 0; i < n; i++) begin
        if (m) begin
          pa.push_back({1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)});
          pb.push_back({1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)});
        end else begin
          pa.push_back(16'($urandom));
          pb.push_back(16'($urandom));
        end
        perr.push_back($urandom_range(0, 7) == 0);
      end
      pbias = 16'($urandom);
      send_pkt(m, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0, 1'b0, 0);
    end

    rdy_rand = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
